// File: rtl/collective_pkg.sv
// Shared types for the collective node: opcodes, status codes, FSM states
// and the per-lane combine step used to build the reduction tree.
package collective_pkg;

    typedef enum logic [2:0] {
        OP_LOAD      = 3'd0,
        OP_ALLGATHER = 3'd1,
        OP_SUM       = 3'd2,
        OP_MAX       = 3'd3,
        OP_MIN       = 3'd4
    } op_e;

    localparam logic [31:0] ST_READY   = 32'd0;
    localparam logic [31:0] ST_DONE    = 32'd1;
    localparam logic [31:0] ST_BADSIZE = 32'd2;
    localparam logic [31:0] ST_BADOP   = 32'd3;

    typedef enum logic [2:0] {
        S_REQ,
        S_CMD_OP,
        S_CMD_SIZE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    // Lanes are sign-extended to this width before combining, so one function
    // serves any lane width up to 64; SUM wraps once truncated back to E bits.
    localparam int LANE_EXT = 64;
    typedef logic signed [LANE_EXT-1:0] lane_t;

    function automatic lane_t lane_combine(input op_e op, input lane_t a, input lane_t b);
        case (op)
            OP_SUM:  return a + b;
            OP_MAX:  return (a > b) ? a : b;
            OP_MIN:  return (a < b) ? a : b;
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/collective_bank.sv
// 1W1R bank, registered read. A same-cycle write and read of one address
// returns the previous contents.
module collective_bank #(
    parameter int W = 128,
    parameter int D = 5
) (
    input  logic         clock,
    input  logic         we,
    input  logic [D-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [D-1:0] raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [2**D];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/collective_node.sv
// Collective successor node: X local banks, LOAD / ALLGATHER / ALLREDUCE over
// X peer ports, status words back to the controller.
//
// state      | meaning
// S_REQ      | announce READY once after reset
// S_CMD_OP   | wait for opcode word
// S_CMD_SIZE | wait for size word, validate it
// S_LOAD     | write controller words round-robin across banks
// S_RUN      | stream banks out, absorb peer beats
// S_DONE     | emit completion/error status, then back to S_CMD_OP
module collective_node
    import collective_pkg::*;
#(
    parameter int X       = 4,
    parameter int W       = 128,
    parameter int E       = 16,
    parameter int D       = 5,
    parameter int NODE_ID = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [X-1:0]   ivalid,
    input  logic [W*X-1:0] idata,
    output logic [X-1:0]   ovalid,
    output logic [W*X-1:0] odata,
    input  logic           controllerivalid,
    input  logic [W-1:0]   controlleridata,
    output logic           controllerovalid,
    output logic [W-1:0]   controllerodata
);

    localparam int CW         = D + 1;
    localparam int BEAT_BYTES = X * W / 8;
    localparam int LANES      = W / E;
    localparam int XW         = (X > 1) ? $clog2(X) : 1;

    state_e        state, state_next;
    op_e           op_q;
    logic [CW-1:0] beats_q, rd_cnt, wr_cnt;
    logic [XW-1:0] load_bank;
    logic [D-1:0]  load_addr;
    logic [31:0]   code_q, code_next, pulse_code;
    logic          pulse, set_code, op_take, size_take, load_wr;

    logic [31:0]   size32, beats_calc;
    logic          size_bad, op_ok, is_reduce, accept, rd_issue, run_done, load_last;

    logic          rd_q1, bcast_q1;
    logic          red_valid;
    logic [D-1:0]  red_addr;
    logic [W-1:0]  red_data, red_next;
    logic [W*X-1:0] odata_next;
    logic [W-1:0]  status_word;

    logic          bank_we    [X];
    logic [D-1:0]  bank_waddr [X];
    logic [W-1:0]  bank_wdata [X];
    logic [W-1:0]  bank_rdata [X];

    assign size32     = controlleridata[31:0];
    assign beats_calc = size32 / 32'(BEAT_BYTES);
    assign size_bad   = ((controlleridata >> 32) != '0) || (size32 == 32'd0) ||
                        ((size32 % 32'(BEAT_BYTES)) != 32'd0) || (beats_calc > 32'(2**D));
    assign op_ok      = ((controlleridata >> 3) == '0) && (controlleridata[2:0] <= 3'd4);

    assign is_reduce = (op_q == OP_SUM) || (op_q == OP_MAX) || (op_q == OP_MIN);
    assign accept    = (state == S_RUN) && (&ivalid) && (wr_cnt < beats_q);
    assign rd_issue  = (state == S_RUN) && (rd_cnt < beats_q);
    assign run_done  = (wr_cnt == beats_q) && !red_valid;
    assign load_last = (load_bank == XW'(X-1)) && ({1'b0, load_addr} == beats_q - 1'b1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_REQ;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pulse      = 1'b0;
        pulse_code = ST_READY;
        set_code   = 1'b0;
        code_next  = ST_DONE;
        op_take    = 1'b0;
        size_take  = 1'b0;
        load_wr    = 1'b0;
        case (state)
            S_REQ: begin
                pulse      = 1'b1;
                state_next = S_CMD_OP;
            end
            S_CMD_OP: if (controllerivalid) begin
                if (op_ok) begin
                    op_take    = 1'b1;
                    state_next = S_CMD_SIZE;
                end else begin
                    set_code   = 1'b1;
                    code_next  = ST_BADOP;
                    state_next = S_DONE;
                end
            end
            S_CMD_SIZE: if (controllerivalid) begin
                if (size_bad) begin
                    set_code   = 1'b1;
                    code_next  = ST_BADSIZE;
                    state_next = S_DONE;
                end else begin
                    size_take  = 1'b1;
                    state_next = (op_q == OP_LOAD) ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: if (controllerivalid) begin
                load_wr = 1'b1;
                if (load_last) begin
                    set_code   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RUN: if (run_done) begin
                set_code   = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                pulse      = 1'b1;
                pulse_code = code_q;
                state_next = S_CMD_OP;
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q      <= OP_LOAD;
            beats_q   <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            load_bank <= '0;
            load_addr <= '0;
            code_q    <= ST_READY;
        end else begin
            if (op_take) op_q <= op_e'(controlleridata[2:0]);
            if (set_code) code_q <= code_next;
            if (size_take) begin
                beats_q   <= beats_calc[CW-1:0];
                rd_cnt    <= '0;
                wr_cnt    <= '0;
                load_bank <= '0;
                load_addr <= '0;
            end
            if (load_wr) begin
                if (load_bank == XW'(X-1)) begin
                    load_bank <= '0;
                    load_addr <= load_addr + 1'b1;
                end else begin
                    load_bank <= load_bank + 1'b1;
                end
            end
            if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
            if (accept)   wr_cnt <= wr_cnt + 1'b1;
        end
    end

    // Reduction tree: port 0 seeds each lane, the remaining ports fold in.
    always_comb begin
        lane_t acc;
        red_next = '0;
        acc      = '0;
        for (int l = 0; l < LANES; l++) begin
            acc = lane_t'(signed'(idata[l*E +: E]));
            for (int k = 1; k < X; k++)
                acc = lane_combine(op_q, acc, lane_t'(signed'(idata[k*W + l*E +: E])));
            red_next[l*E +: E] = acc[E-1:0];
        end
    end

    always_comb begin
        for (int k = 0; k < X; k++) begin
            bank_we[k]    = 1'b0;
            bank_waddr[k] = '0;
            bank_wdata[k] = '0;
            if (load_wr && load_bank == XW'(k)) begin
                bank_we[k]    = 1'b1;
                bank_waddr[k] = load_addr;
                bank_wdata[k] = controlleridata;
            end
            if (accept && op_q == OP_ALLGATHER && k != NODE_ID) begin
                bank_we[k]    = 1'b1;
                bank_waddr[k] = wr_cnt[D-1:0];
                bank_wdata[k] = idata[k*W +: W];
            end
            if (red_valid && k == NODE_ID) begin
                bank_we[k]    = 1'b1;
                bank_waddr[k] = red_addr;
                bank_wdata[k] = red_data;
            end
        end
    end

    for (genvar k = 0; k < X; k++) begin : g_bank
        collective_bank #(.W(W), .D(D)) u_bank (
            .clock (clock),
            .we    (bank_we[k]),
            .waddr (bank_waddr[k]),
            .wdata (bank_wdata[k]),
            .raddr (rd_cnt[D-1:0]),
            .rdata (bank_rdata[k])
        );
    end

    always_comb begin
        odata_next = '0;
        for (int k = 0; k < X; k++)
            odata_next[k*W +: W] = bcast_q1 ? bank_rdata[NODE_ID] : bank_rdata[k];
    end

    always_comb begin
        status_word = '0;
        if (pulse) status_word[W-32 +: 32] = pulse_code;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q1            <= 1'b0;
            bcast_q1         <= 1'b0;
            red_valid        <= 1'b0;
            red_addr         <= '0;
            red_data         <= '0;
            ovalid           <= '0;
            odata            <= '0;
            controllerovalid <= 1'b0;
            controllerodata  <= '0;
        end else begin
            rd_q1            <= rd_issue;
            bcast_q1         <= (op_q == OP_ALLGATHER);
            red_valid        <= accept && is_reduce;
            red_addr         <= wr_cnt[D-1:0];
            red_data         <= red_next;
            ovalid           <= {X{rd_q1}};
            odata            <= rd_q1 ? odata_next : '0;
            controllerovalid <= pulse;
            controllerodata  <= status_word;
        end
    end

endmodule

// File: tb/tb_collective_node.sv
// Directed bench for collective_node (X=4, W=128, E=16, D=5, NODE_ID=1):
// a reduce-vector table plus hand-written LOAD, partial-ivalid, error and reset sequences.
module tb_collective_node;
    import collective_pkg::*;

    localparam int X   = 4;
    localparam int W   = 128;
    localparam int E   = 16;
    localparam int D   = 5;
    localparam int NID = 1;
    localparam int BB  = X * W / 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [X-1:0]   ivalid = '0;
    logic [W*X-1:0] idata = '0;
    logic [X-1:0]   ovalid;
    logic [W*X-1:0] odata;
    logic           controllerivalid = 1'b0;
    logic [W-1:0]   controlleridata = '0;
    logic           controllerovalid;
    logic [W-1:0]   controllerodata;

    collective_node #(.X(X), .W(W), .E(E), .D(D), .NODE_ID(NID)) dut (
        .clock            (clock),
        .reset            (reset),
        .ivalid           (ivalid),
        .idata            (idata),
        .ovalid           (ovalid),
        .odata            (odata),
        .controllerivalid (controllerivalid),
        .controlleridata  (controlleridata),
        .controllerovalid (controllerovalid),
        .controllerodata  (controllerodata)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W*X-1:0] out_q [$];
    logic [31:0]    st_q  [$];
    logic [W-1:0]   mdl   [X][2**D];
    logic [W*X-1:0] beat_buf [2];

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a0, a1, a2, a3;
        logic [15:0] res;
    } vec_t;
    vec_t tbl [8];

    initial forever begin
        @(negedge clock);
        if (ovalid != '0) begin
            n_cmp++;
            if (ovalid !== 4'b1111) begin
                n_fail++;
                $display("FAIL ovalid_all_ports: got %b want 1111", ovalid);
            end
            out_q.push_back(odata);
        end
        if (controllerovalid) st_q.push_back(controllerodata[W-32 +: 32]);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    function automatic logic [W*X-1:0] pack4(input logic [15:0] a0, a1, a2, a3);
        return {rep(a3), rep(a2), rep(a1), rep(a0)};
    endfunction

    task automatic chk(input string name, input logic [W*X-1:0] act, input logic [W*X-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_ctrl(input logic [W-1:0] w);
        controlleridata  = w;
        controllerivalid = 1'b1;
        tick();
        controllerivalid = 1'b0;
        controlleridata  = '0;
    endtask

    task automatic wait_status(input logic [31:0] exp, input string name, input int limit);
        int n;
        logic [31:0] got;
        n = 0;
        while (st_q.size() == 0 && n < limit) begin
            tick();
            n++;
        end
        if (st_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no status within %0d cycles, want code %0d", name, limit, exp);
        end else begin
            got = st_q.pop_front();
            chk_int(name, int'(got), int'(exp));
        end
    endtask

    task automatic run_coll(input logic [2:0] op, input int nb, input string name);
        logic [W*X-1:0] exp [2];
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < X; k++)
                exp[b][k*W +: W] = (op == OP_ALLGATHER) ? mdl[NID][b] : mdl[k][b];
        out_q.delete();
        st_q.delete();
        send_ctrl(W'(op));
        send_ctrl(W'(nb * BB));
        for (int b = 0; b < nb; b++) begin
            idata  = beat_buf[b];
            ivalid = '1;
            tick();
        end
        ivalid = '0;
        idata  = '0;
        wait_status(ST_DONE, {name, "_status"}, 50);
        repeat (3) tick();
        chk_int({name, "_beats"}, out_q.size(), nb);
        for (int b = 0; b < nb; b++)
            if (b < out_q.size()) chk($sformatf("%s_out%0d", name, b), out_q[b], exp[b]);
        if (op == OP_ALLGATHER)
            for (int b = 0; b < nb; b++)
                for (int k = 0; k < X; k++)
                    if (k != NID) mdl[k][b] = beat_buf[b][k*W +: W];
    endtask

    task automatic bad_case(input logic [W-1:0] op_word, input bit send_size,
                            input logic [W-1:0] size_word, input logic [31:0] code, input string name);
        out_q.delete();
        st_q.delete();
        send_ctrl(op_word);
        if (send_size) send_ctrl(size_word);
        wait_status(code, {name, "_status"}, 20);
        repeat (4) tick();
        chk_int({name, "_no_ovalid"}, out_q.size(), 0);
    endtask

    initial begin
        logic [W*X-1:0] exp0;

        tbl[0] = '{OP_SUM, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h8000};
        tbl[1] = '{OP_MAX, 16'hFFFD, 16'h0005, 16'hFFF9, 16'h0002, 16'h0005};
        tbl[2] = '{OP_MIN, 16'hFFFD, 16'h0005, 16'hFFF9, 16'h0002, 16'hFFF9};
        tbl[3] = '{OP_SUM, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFC};
        tbl[4] = '{OP_MAX, 16'h8000, 16'h8001, 16'h8000, 16'h8000, 16'h8001};
        tbl[5] = '{OP_MIN, 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFE, 16'h8000};
        tbl[6] = '{OP_SUM, 16'h1234, 16'h1111, 16'h0001, 16'h0002, 16'h2348};
        tbl[7] = '{OP_MIN, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0001};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_ovalid", W*X'(ovalid), '0);
        chk("reset_odata", odata, '0);
        chk("reset_ctrl_ovalid", W*X'(controllerovalid), '0);
        out_q.delete();
        st_q.delete();
        reset = 1'b0;
        wait_status(ST_READY, "req_ready", 3);
        chk_int("req_no_ovalid", out_q.size(), 0);

        // LOAD 128 bytes: word n -> bank n%4, address n/4
        out_q.delete();
        st_q.delete();
        send_ctrl(W'(OP_LOAD));
        send_ctrl(W'(128));
        for (int n = 0; n < 8; n++) begin
            send_ctrl(rep(16'(16'hA000 + n)));
            if (n == 3) tick();
            mdl[n % X][n / X] = rep(16'(16'hA000 + n));
        end
        wait_status(ST_DONE, "load_status", 20);
        repeat (3) tick();
        chk_int("load_no_ovalid", out_q.size(), 0);

        // Two-beat MAX streams out the loaded banks, then an ALLGATHER reads back its result
        beat_buf[0] = pack4(16'h0001, 16'hFFFE, 16'h0003, 16'h8000);
        beat_buf[1] = pack4(16'h7000, 16'h7001, 16'h0000, 16'hFFFF);
        run_coll(OP_MAX, 2, "max2");
        mdl[NID][0] = rep(16'h0003);
        mdl[NID][1] = rep(16'h7001);
        for (int b = 0; b < 2; b++)
            beat_buf[b] = pack4(16'(16'hC000 + 16*b), 16'(16'hC001 + 16*b),
                                16'(16'hC002 + 16*b), 16'(16'hC003 + 16*b));
        run_coll(OP_ALLGATHER, 2, "ag2");

        for (int i = 0; i < 8; i++) begin
            beat_buf[0] = pack4(tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].a3);
            run_coll(tbl[i].op, 1, $sformatf("red%0d", i));
            mdl[NID][0] = rep(tbl[i].res);
            beat_buf[0] = pack4(16'(256*(i+1)), 16'(256*(i+1) + 1), 16'(256*(i+1) + 2), 16'(256*(i+1) + 3));
            run_coll(OP_ALLGATHER, 1, $sformatf("agchk%0d", i));
        end

        // Partial ivalid must neither be reduced nor counted
        for (int k = 0; k < X; k++) exp0[k*W +: W] = mdl[k][0];
        out_q.delete();
        st_q.delete();
        send_ctrl(W'(OP_SUM));
        send_ctrl(W'(64));
        idata  = pack4(16'h1111, 16'h1111, 16'h1111, 16'h1111);
        ivalid = 4'b1011;
        repeat (3) tick();
        ivalid = 4'b0111;
        tick();
        ivalid = '0;
        repeat (3) tick();
        chk_int("partial_no_done", st_q.size(), 0);
        idata  = pack4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        ivalid = '1;
        tick();
        ivalid = '0;
        idata  = '0;
        wait_status(ST_DONE, "partial_status", 20);
        repeat (3) tick();
        chk_int("partial_beats", out_q.size(), 1);
        if (out_q.size() >= 1) chk("partial_out", out_q[0], exp0);
        mdl[NID][0] = rep(16'h00A0);
        beat_buf[0] = pack4(16'hD000, 16'hD001, 16'hD002, 16'hD003);
        run_coll(OP_ALLGATHER, 1, "partial_chk");

        bad_case(W'(OP_SUM), 1'b1, W'(48), ST_BADSIZE, "size48");
        bad_case(W'(OP_ALLGATHER), 1'b1, W'(0), ST_BADSIZE, "size0");
        bad_case(W'(OP_MAX), 1'b1, W'(33 * BB), ST_BADSIZE, "size33beats");
        bad_case(W'(7), 1'b0, '0, ST_BADOP, "op7");

        // Asynchronous reset while beats are streaming out
        out_q.delete();
        st_q.delete();
        send_ctrl(W'(OP_SUM));
        send_ctrl(W'(128));
        tick();
        tick();
        chk("pre_reset_ovalid", W*X'(ovalid), W*X'(4'b1111));
        #2;
        reset = 1'b1;
        #1;
        chk("abort_ovalid", W*X'(ovalid), '0);
        chk("abort_odata", odata, '0);
        chk("abort_ctrl_ovalid", W*X'(controllerovalid), '0);
        repeat (2) @(posedge clock);
        #1;
        chk_int("abort_no_status", st_q.size(), 0);
        st_q.delete();
        out_q.delete();
        reset = 1'b0;
        wait_status(ST_READY, "abort_req_ready", 3);
        beat_buf[0] = pack4(16'hE000, 16'hE001, 16'hE002, 16'hE003);
        run_coll(OP_ALLGATHER, 1, "post_reset_ag");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
